// File: rtl/uart_instr_loader_pkg.sv
// Shared encodings for the UART program loader: loader FSM states,
// receiver states and 8N1 frame constants.
package uart_instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_DONE
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  localparam int BIT_CNT_W      = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_instr_loader_rx.sv
// 8N1 UART receiver, LSB first: 2-flop synchronizer, mid-bit sampling,
// one-cycle byte_valid on a good stop bit, one-cycle frame_err otherwise.
module uart_rx
  import uart_instr_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]                sync_q, sync_d;
  logic                      prev_q, prev_d;
  rx_state_e                 st_q, st_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]      bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]                byte_q, byte_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], rx};
    prev_d  = rx_s;
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit is a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          if (bit_q == BIT_CNT_W'(UART_DATA_BITS - 1)) begin
            bit_d = '0;
            st_d  = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d = 1'b1;
            st_d   = RX_IDLE;
          end else if (bit_q == BIT_CNT_W'(UART_STOP_BITS - 1)) begin
            valid_d = 1'b1;
            byte_d  = shreg_q;
            st_d    = RX_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_instr_loader.sv
// Serial program loader: parses a big-endian word count plus words from the
// UART and emits one word-addressed imem write per assembled word.
module uart_instr_loader
  import uart_instr_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEMORY_SIZE  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic        write_enable,
  output logic        load_done,
  output logic        err_framing,
  output logic        err_overflow
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  ld_state_e   st_q, st_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] data_q, data_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        inc_q, inc_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;
  logic [15:0] n_full;
  logic        addr_ok;

  assign n_full  = {len_q[15:8], rx_byte};
  assign addr_ok = {16'd0, addr_q} < MEMORY_SIZE;

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    wcnt_d = wcnt_q;
    bcnt_d = bcnt_q;
    data_d = data_q;
    addr_d = addr_q;
    we_d   = 1'b0;
    inc_d  = 1'b0;
    done_d = done_q;
    ferr_d = ferr_q | rx_ferr;
    ovf_d  = ovf_q;
    // Losing enable wins over everything, including a byte landing this cycle.
    if (st_q != ST_IDLE && !enable) begin
      st_d   = ST_IDLE;
      len_d  = '0;
      wcnt_d = '0;
      bcnt_d = '0;
      addr_d = '0;
      done_d = 1'b0;
    end else begin
      if (inc_q) addr_d = addr_q + 16'd1;
      case (st_q)
        ST_IDLE: begin
          if (enable) st_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_d[15:8] = rx_byte;
            st_d        = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            len_d = n_full;
            if (n_full == 16'd0) begin
              st_d   = ST_DONE;
              done_d = 1'b1;
            end else begin
              st_d = ST_DATA;
              if ({16'd0, n_full} > MEMORY_SIZE) ovf_d = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            data_d = {data_q[23:0], rx_byte};
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              we_d   = addr_ok;
              inc_d  = 1'b1;
              wcnt_d = wcnt_q + 16'd1;
            end
          end
          if (inc_q && wcnt_q == len_q) begin
            st_d   = ST_DONE;
            done_d = 1'b1;
          end
        end
        ST_DONE: st_d = ST_DONE;
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= ST_IDLE;
      len_q  <= '0;
      wcnt_q <= '0;
      bcnt_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      inc_q  <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      wcnt_q <= wcnt_d;
      bcnt_q <= bcnt_d;
      data_q <= data_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      inc_q  <= inc_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign address      = {16'd0, addr_q};
  assign data         = data_q;
  assign write_enable = we_q;
  assign load_done    = done_q;
  assign err_framing  = ferr_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: table of clean program loads plus
// hand-written overflow, framing, abort and glitch sequences.
module tb_uart_instr_loader;

  localparam int CPB = 8;
  localparam int MEM = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        rx;
  logic [31:0] address;
  logic [31:0] data;
  logic        write_enable;
  logic        load_done;
  logic        err_framing;
  logic        err_overflow;

  always #5 clock = ~clock;

  uart_instr_loader #(.CLKS_PER_BIT(CPB), .MEMORY_SIZE(MEM)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .rx           (rx),
    .address      (address),
    .data         (data),
    .write_enable (write_enable),
    .load_done    (load_done),
    .err_framing  (err_framing),
    .err_overflow (err_overflow)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clock) begin
    if (write_enable === 1'b1) begin
      wr_addr.push_back(address);
      wr_data.push_back(data);
    end
  end

  typedef struct packed {
    logic [15:0]      n;
    logic [2:0]       nw;
    logic [3:0][31:0] w;
  } vec_t;

  vec_t vecs[4];

  function automatic vec_t mk(input logic [15:0] n, input logic [2:0] nw,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2);
    vec_t v;
    v.n    = n;
    v.nw   = nw;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.w[3] = 32'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    enable = 1'b0;
    rx     = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (load_done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(load_done), 32'd1);
  endtask

  initial begin
    int bad;
    reset  = 1'b1;
    enable = 1'b0;
    rx     = 1'b1;

    vecs[0] = mk(16'd2, 3'd2, 32'h20080005, 32'h2009000A, 32'h0);
    vecs[1] = mk(16'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    vecs[2] = mk(16'd1, 3'd1, 32'hDEADBEEF, 32'h0, 32'h0);
    vecs[3] = mk(16'd3, 3'd3, 32'h00000000, 32'hFFFFFFFF, 32'h80000001);

    repeat (3) @(negedge clock);
    chk("rst_address", address, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_ferr", 32'(err_framing), 32'd0);
    chk("rst_ovf", 32'(err_overflow), 32'd0);

    // Clean loads from the table.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      enable = 1'b1;
      send_byte(vecs[i].n[15:8], 1'b1);
      send_byte(vecs[i].n[7:0], 1'b1);
      for (int k = 0; k < int'(vecs[i].nw); k++) send_word(vecs[i].w[k]);
      wait_done($sformatf("v%0d_done", i));
      chk($sformatf("v%0d_nwr", i), 32'(wr_addr.size()), 32'(vecs[i].nw));
      for (int k = 0; k < int'(vecs[i].nw); k++) begin
        chk($sformatf("v%0d_addr%0d", i, k),
            (k < wr_addr.size()) ? wr_addr[k] : 32'hxxxxxxxx, 32'(k));
        chk($sformatf("v%0d_data%0d", i, k),
            (k < wr_data.size()) ? wr_data[k] : 32'hxxxxxxxx, vecs[i].w[k]);
      end
      chk($sformatf("v%0d_ferr", i), 32'(err_framing), 32'd0);
      chk($sformatf("v%0d_ovf", i), 32'(err_overflow), 32'd0);
    end

    // Overflow: 66 words into a 64-deep memory.
    do_reset();
    enable = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'h42, 1'b1);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    for (int i = 0; i < 66; i++) begin
      send_word(32'hA0000000 + 32'(i));
      if (i == 64) chk("ovf_not_done_early", 32'(load_done), 32'd0);
    end
    wait_done("ovf_done");
    chk("ovf_nwr", 32'(wr_addr.size()), 32'd64);
    bad = 0;
    for (int k = 0; k < wr_addr.size(); k++)
      if (wr_addr[k] !== 32'(k) || wr_data[k] !== 32'hA0000000 + 32'(k)) bad++;
    chk("ovf_writes_bad", 32'(bad), 32'd0);

    // Framing error: bad byte dropped, retransmission completes the word.
    do_reset();
    enable = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b0);
    chk("fr_flag", 32'(err_framing), 32'd1);
    send_word(32'h11223344);
    wait_done("fr_done");
    chk("fr_nwr", 32'(wr_addr.size()), 32'd1);
    chk("fr_data", (wr_data.size() > 0) ? wr_data[0] : 32'hxxxxxxxx, 32'h11223344);
    chk("fr_addr", (wr_addr.size() > 0) ? wr_addr[0] : 32'hxxxxxxxx, 32'd0);

    // Abort mid-word, then restart from the header.
    do_reset();
    enable = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    enable = 1'b0;
    repeat (5) @(negedge clock);
    chk("ab_no_write", 32'(wr_addr.size()), 32'd0);
    chk("ab_not_done", 32'(load_done), 32'd0);
    enable = 1'b1;
    repeat (2) @(negedge clock);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(32'hDEADBEEF);
    wait_done("ab_done");
    chk("ab_nwr", 32'(wr_addr.size()), 32'd1);
    chk("ab_addr", (wr_addr.size() > 0) ? wr_addr[0] : 32'hxxxxxxxx, 32'd0);
    chk("ab_data", (wr_data.size() > 0) ? wr_data[0] : 32'hxxxxxxxx, 32'hDEADBEEF);

    // Short low glitch must not look like a byte.
    do_reset();
    enable = 1'b1;
    repeat (2) @(negedge clock);
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    chk("gl_ferr", 32'(err_framing), 32'd0);
    chk("gl_done", 32'(load_done), 32'd0);
    chk("gl_nwr", 32'(wr_addr.size()), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_done("gl_hdr_intact");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_instr_loader.md
Name: uart_instr_loader

Overview:
- Serial program loader sitting directly upstream of instruction memory; replaces the fixed-content loader that drives the imem load-mux A input and imem write data.
- Receives a program over an 8N1 UART line while the CPU is halted (run_switch low), assembles big-endian 32-bit words, and issues one word-addressed write per word.
- Signals completion so the operator or a board LED knows when run_switch may be raised.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- MEMORY_SIZE, 64, instruction memory depth in words; writes at or beyond this index are suppressed.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  loader active; tie to ~run_switch.
- rx  in  1  asynchronous UART receive line, idle high.
- address  out  32  word index into instruction memory; feeds imem load-mux input A.
- data  out  32  assembled instruction word; feeds imem input_data.
- write_enable  out  1  one-cycle write strobe for the current address/data.
- load_done  out  1  high once the whole program has been received; held until enable falls or reset.
- err_framing  out  1  sticky; a byte had stop bit = 0.
- err_overflow  out  1  sticky; header word count exceeded MEMORY_SIZE.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, receiver to idle, byte and word counters 0.
- rx passes through a 2-flop synchronizer before any use; this adds 2 cycles of input latency.
- Receiver (8N1, LSB first):
  - A falling edge on synchronized rx while idle starts a frame.
  - Start bit is re-sampled at CLKS_PER_BIT/2; if high, the frame is a glitch and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after that; the stop bit is sampled likewise.
  - Stop = 1: raise a one-cycle byte_valid with the byte.
  - Stop = 0: discard the byte, set err_framing.
- Stream format: 2-byte big-endian word count N, then N words of 4 bytes each, MSB first.
- FSM states and transitions:
  - IDLE: when enable=1 -> LEN_HI.
  - LEN_HI: on byte -> latch N[15:8], go to LEN_LO.
  - LEN_LO: on byte -> latch N[7:0].
    - N=0 -> DONE.
    - Otherwise -> DATA; if N > MEMORY_SIZE, set err_overflow.
  - DATA: shift each byte into the word register (data <= {data[23:0], byte}); a 2-bit byte counter tracks position.
    - On the 4th byte, in the next cycle: write_enable=1 for exactly one cycle with the completed data and the current address, but only if address < MEMORY_SIZE.
    - In the cycle after the strobe: address increments.
    - When words_received == N after a write -> DONE.
  - DONE: load_done=1; further bytes are ignored.
  - Any state except IDLE: enable=0 -> IDLE. This clears the byte counter, word count, address and load_done. err_* are kept.
- Abort and restart: deasserting enable mid-word aborts the load without any partial write; re-enabling restarts from header parsing.
- Write-path constraint: address and data are stable during and after the strobe until the next byte completes, because imem samples on the clock edge.
- Address is a word index, never a byte address; imem is word-addressed.
- Counter widths: word counter is 16 bits; address is zero-extended to 32.
- Receiver operation:
  - The receiver keeps running in IDLE, but bytes arriving there are dropped.
  - A byte completing in the same cycle enable falls is dropped.
- Reset mid-frame: the receiver returns to idle on the next edge; the partial byte is lost.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, LEN_HI, LEN_LO, DATA, DONE) and the UART frame constants (8 data bits, 1 stop bit).
- Sub-module uart_rx:
  - Ports: clock, reset, rx, byte_out[7:0], byte_valid, frame_err.
  - Contains the synchronizer, bit counter and sample counter.
- The top level holds the FSM, word assembly, address and strobe.

Test Plan:
1. Header 0x0002, words 0x20080005, 0x2009000A (CLKS_PER_BIT=8) -> two write_enable pulses at address 0 then 1 with those data values; load_done=1 after the second; err_*=0.
2. Header 0x0000 -> load_done=1 right after the 2nd header byte; no write_enable pulse.
3. Header 0x0042 (66) with MEMORY_SIZE=64, 66 words -> err_overflow=1; exactly 64 strobes at addresses 0..63; load_done=1 after word 66.
4. A byte sent with stop bit 0, then valid bytes -> err_framing=1; the bad byte is not counted; the load completes correctly with the retransmitted byte.
5. enable dropped after 2 bytes of word 1, then raised and a full stream 0x0001, 0xDEADBEEF sent -> no write before the drop; single write addr 0 data 0xDEADBEEF; load_done=1.
6. A 2-cycle low glitch on rx while idle -> no byte_valid, no error, FSM unchanged.
